// File: rtl/math_pkg.sv
// math_pkg: helpers and the add/sub operation encoding shared across the math datapath.
package math_pkg;

   typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_op_e;

   function automatic int ceil_division(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   function automatic int min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: one combinational W-bit slice of the adder/subtractor.
// For subtract, ci_i is the borrow-in and co_o the borrow-out, so slices chain the same way for both ops.
module addsub_chunk
   import math_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         op_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   logic         is_sub;
   logic [W-1:0] b_eff;
   logic         cin_eff;
   logic [W:0]   sum;

   assign is_sub  = (addsub_op_e'(op_i) == SUB);
   assign b_eff   = is_sub ? ~b_i : b_i;
   assign cin_eff = is_sub ? ~ci_i : ci_i;
   assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, cin_eff};
   assign s_o     = sum[W-1:0];
   assign co_o    = is_sub ? ~sum[W] : sum[W];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked, fully pipelined add/sub with a global-stall valid/ready handshake.
// Define PIPELINED_ADDSUB_OVERFLOW_EN to build the signed-overflow output; otherwise it reads 0.
module pipelined_addsub
   import math_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow
);

   localparam int STAGES  = ceil_division(WIDTH, CHUNK);
   localparam int LAST_SW = WIDTH - (STAGES - 1) * CHUNK;

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage gi resolves bits [HI:LO]; res_q carries all finished low slices, g_fwd the unused high operands.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * CHUNK;
      localparam int SW = min(CHUNK, WIDTH - LO);
      localparam int HI = LO + SW - 1;

      logic [SW-1:0] a_slice, b_slice, s_slice;
      logic          op_in, ci_in, valid_in, cy_d;
      logic [HI:0]   res_d;
      logic          valid_q, cy_q;
      logic [HI:0]   res_q;

      if (gi == 0) begin : g_src
         assign a_slice  = in1[HI:LO];
         assign b_slice  = in2[HI:LO];
         assign op_in    = op;
         assign ci_in    = 1'b0;
         assign valid_in = in_valid;
         assign res_d    = s_slice;
      end else begin : g_src
         assign a_slice  = g_stage[gi-1].g_fwd.a_q[HI:LO];
         assign b_slice  = g_stage[gi-1].g_fwd.b_q[HI:LO];
         assign op_in    = g_stage[gi-1].g_fwd.op_q;
         assign ci_in    = g_stage[gi-1].cy_q;
         assign valid_in = g_stage[gi-1].valid_q;
         assign res_d    = {s_slice, g_stage[gi-1].res_q};
      end

      addsub_chunk #(.W(SW)) u_chunk (
         .a_i  (a_slice),
         .b_i  (b_slice),
         .op_i (op_in),
         .ci_i (ci_in),
         .s_o  (s_slice),
         .co_o (cy_d)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            cy_q    <= 1'b0;
            res_q   <= '0;
         end else if (advance) begin
            valid_q <= valid_in;
            cy_q    <= cy_d;
            res_q   <= res_d;
         end
      end

      if (gi < STAGES - 1) begin : g_fwd
         logic                 op_q;
         logic [WIDTH-1:HI+1]  a_up, b_up;
         logic [WIDTH-1:HI+1]  a_q, b_q;

         if (gi == 0) begin : g_up
            assign a_up = in1[WIDTH-1:HI+1];
            assign b_up = in2[WIDTH-1:HI+1];
         end else begin : g_up
            assign a_up = g_stage[gi-1].g_fwd.a_q[WIDTH-1:HI+1];
            assign b_up = g_stage[gi-1].g_fwd.b_q[WIDTH-1:HI+1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               op_q <= 1'b0;
               a_q  <= '0;
               b_q  <= '0;
            end else if (advance) begin
               op_q <= op_in;
               a_q  <= a_up;
               b_q  <= b_up;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign out       = g_stage[STAGES-1].res_q;
   assign carry     = g_stage[STAGES-1].cy_q;

`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
   // Sign bits come from the last slice's operands, which already travel with the transaction.
   logic ovf_q, ovf_d, a_msb, b_msb, r_msb, last_sub;

   assign a_msb    = g_stage[STAGES-1].a_slice[LAST_SW-1];
   assign b_msb    = g_stage[STAGES-1].b_slice[LAST_SW-1];
   assign r_msb    = g_stage[STAGES-1].s_slice[LAST_SW-1];
   assign last_sub = (addsub_op_e'(g_stage[STAGES-1].op_in) == SUB);
   assign ovf_d    = (last_sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (advance) begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for an 8-bit/3-bit-chunk instance and a 1-bit instance.
module tb_pipelined_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       in_valid8, in_ready8, op8, out_valid8, out_ready8, c8, ov8;
   logic [7:0] a8, b8, out8;
   logic       in_valid1, in_ready1, op1, out_valid1, out_ready1, c1, ov1;
   logic [0:0] a1, b1, out1;

   logic [1:0] ready_mode;
   logic       rnd_bit = 1'b1;

   int pass_cnt = 0, total_cnt = 0;
   int sb_pass = 0, sb_total = 0;

   logic [9:0] q8[$];
   logic [9:0] q1[$];
   logic [9:0] exp8, exp1;

   assign out_ready8 = (ready_mode == 2'd0) ? 1'b1 : (ready_mode == 2'd1) ? 1'b0 : rnd_bit;

   always @(posedge clk) begin
      #2;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   pipelined_addsub #(.WIDTH(8), .CHUNK(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
      .in1(a8), .in2(b8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
      .carry(c8), .overflow(ov8)
   );

   pipelined_addsub #(.WIDTH(1), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
      .in1(a1), .in2(b1), .out_valid(out_valid1), .out_ready(out_ready1), .out(out1),
      .carry(c1), .overflow(ov1)
   );

   // Reference: plain modular and signed integer arithmetic. Returns {overflow, carry, result}.
   function automatic logic [9:0] model(input int w, input bit sub, input int unsigned a, input int unsigned b);
      int unsigned m  = 32'd1 << w;
      int          mh = int'(m / 2);
      int unsigned r;
      bit          c, ov;
      int          sa, sb, sr;
      r  = sub ? (a + m - b) % m : (a + b) % m;
      c  = sub ? (a < b) : ((a + b) >= m);
      sa = (int'(a) >= mh) ? int'(a) - int'(m) : int'(a);
      sb = (int'(b) >= mh) ? int'(b) - int'(m) : int'(b);
      sr = sub ? sa - sb : sa + sb;
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
      ov = (sr < -mh) || (sr >= mh);
`else
      ov = 1'b0;
`endif
      return {ov, c, 8'(r)};
   endfunction

   // Monitor: record expectations on acceptance, compare on delivery; reset discards in-flight work.
   always @(negedge clk) begin
      if (!rst_n) begin
         q8.delete();
         q1.delete();
      end else begin
         if (out_valid8 && out_ready8) begin
            sb_total++;
            if (q8.size() == 0) begin
               $display("FAIL sb8_unexpected: got 0x%0h expected no result", {ov8, c8, out8});
            end else begin
               exp8 = q8.pop_front();
               if ({ov8, c8, out8} === exp8) sb_pass++;
               else $display("FAIL sb8: got {ov,c,out}=0x%0h expected 0x%0h", {ov8, c8, out8}, exp8);
            end
         end
         if (in_valid8 && in_ready8) q8.push_back(model(8, op8, a8, b8));
         if (out_valid1 && out_ready1) begin
            sb_total++;
            if (q1.size() == 0) begin
               $display("FAIL sb1_unexpected: got 0x%0h expected no result", {ov1, c1, 7'd0, out1});
            end else begin
               exp1 = q1.pop_front();
               if ({ov1, c1, 7'd0, out1} === exp1) sb_pass++;
               else $display("FAIL sb1: got {ov,c,out}=0x%0h expected 0x%0h", {ov1, c1, 7'd0, out1}, exp1);
            end
         end
         if (in_valid1 && in_ready1) q1.push_back(model(1, op1, a1, b1));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic send8(input logic o, input logic [7:0] a, input logic [7:0] b);
      bit acc = 1'b0;
      int guard = 0;
      op8 = o; a8 = a; b8 = b; in_valid8 = 1'b1;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = in_ready8;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) begin
         total_cnt++;
         $display("FAIL send8_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
   endtask

   task automatic send1(input logic o, input logic a, input logic b);
      bit acc = 1'b0;
      int guard = 0;
      op1 = o; a1 = a; b1 = b; in_valid1 = 1'b1;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = in_ready1;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) begin
         total_cnt++;
         $display("FAIL send1_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      in_valid8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
      in_valid1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
      out_ready1 = 1'b1;
      ready_mode = 2'd0;

      #2;
      check("rst_valid8", 32'(out_valid8), 0);
      check("rst_out8", 32'(out8), 0);
      check("rst_carry8", 32'(c8), 0);
      check("rst_ovf8", 32'(ov8), 0);
      check("rst_ready8", 32'(in_ready8), 1);
      check("rst_valid1", 32'(out_valid1), 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency and the directed corner cases
      send8(1'b0, 8'hFF, 8'h01);
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency8", 32'(n), 2);
      send8(1'b1, 8'h00, 8'h01);
      send8(1'b1, 8'h80, 8'h01);
      send8(1'b0, 8'h7F, 8'h01);
      send8(1'b1, 8'h10, 8'h20);
      send8(1'b0, 8'h12, 8'h34);
      in_valid8 = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Fill the pipe against a stalled consumer, then drain
      ready_mode = 2'd1;
      send8(1'b0, 8'h11, 8'h22);
      send8(1'b1, 8'h05, 8'h09);
      send8(1'b0, 8'h80, 8'h80);
      in_valid8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready8), 0);
         check("stall_out_valid", 32'(out_valid8), 1);
         check("stall_out_held", 32'({ov8, c8, out8}), (q8.size() > 0) ? 32'(q8[0]) : 32'hFFFF_FFFF);
      end
      @(posedge clk);
      #1;
      ready_mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("stall_drain", 32'(q8.size()), 0);

      // Reset with two transactions in flight
      send8(1'b0, 8'h01, 8'h02);
      send8(1'b1, 8'h30, 8'h03);
      in_valid8 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid8), 0);
      check("midrst_out", 32'(out8), 0);
      check("midrst_carry", 32'(c8), 0);
      check("midrst_ovf", 32'(ov8), 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("postrst_valid", 32'(out_valid8), 0);
      end
      @(posedge clk);
      #1;

      // Random traffic with a randomly stalling consumer
      ready_mode = 2'd2;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid8 = 1'b0;
            @(posedge clk);
            #1;
         end
         send8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      in_valid8 = 1'b0;
      ready_mode = 2'd0;
      n = 0;
      while (q8.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rand_drain8", 32'(q8.size()), 0);

      // Single-bit instance
      send1(1'b0, 1'b1, 1'b1);
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency1", 32'(n), 0);
      send1(1'b1, 1'b0, 1'b1);
      send1(1'b1, 1'b1, 1'b0);
      send1(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         send1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      in_valid1 = 1'b0;
      n = 0;
      while (q1.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rand_drain1", 32'(q1.size()), 0);

      repeat (2) @(posedge clk);
      pass_cnt  += sb_pass;
      total_cnt += sb_total;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Chunked, fully pipelined two's-complement adder/subtractor with a per-transaction operation select and valid/ready flow control. Each pipeline stage resolves one CHUNK-bit slice and passes its carry/borrow to the next stage; operand slices are skewed in and results are de-skewed out, so one full-width result leaves per cycle. It is the general arithmetic stage of the math datapath, feeding accumulators and comparators that need bounded combinational depth at any WIDTH.

## Interface
- WIDTH, default 32: operand/result width, ≥1.
- CHUNK, default 8: bits resolved per stage, 1 ≤ CHUNK ≤ WIDTH.
- Derived: STAGES = ceil_division(WIDTH, CHUNK); the last slice width is min(CHUNK, WIDTH − (STAGES−1)·CHUNK).

- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  block accepts this cycle.
- op  in  1  0 = add (in1+in2), 1 = subtract (in1−in2).
- in1, in2  in  WIDTH  operands.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result, mod 2^WIDTH.
- carry  out  1  add: carry-out; sub: borrow (in1 < in2 unsigned).
- overflow  out  1  signed overflow.

## Operation
- Accept when in_valid && in_ready; stage k (0 = LSB slice) computes slice k using the carry/borrow registered by stage k−1; stage 0 uses carry-in 0.
- op, the upper operand slices, and the valid bit travel with the transaction; the lower result slices are held in delay registers until the final stage.
- Add: {carry,out} = in1 + in2. Sub: out = in1 − in2; carry = borrow out of the MSB slice.
- overflow, add: in1[MSB]==in2[MSB] && out[MSB]!=in1[MSB]; sub: in1[MSB]!=in2[MSB] && out[MSB]!=in1[MSB].
- Flow control is a global stall: advance = !out_valid || out_ready; in_ready = advance. When advance is 0, every register (data and valid) holds. Bubbles (in_valid=0 while advancing) propagate as valid=0.
- Results are delivered strictly in acceptance order; nothing is dropped or duplicated.
- WIDTH==1: STAGES=1; same handshake, single register stage.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, out=0, carry=0, overflow=0, and all internal carries and delay registers 0. in_ready reads 1 while in reset is released and the pipe is empty.
- Latency: a transaction accepted at edge t has out_valid high after edge t+STAGES−1 (visible in the cycle after the STAGES-th accepting edge counting t as the first), with no stall. Each stalled cycle adds one.
- Throughput: one result per cycle while out_ready=1.
- out, carry, and overflow are registered. They are stable and unchanged while out_valid && !out_ready.
- in_ready depends combinationally on out_ready only; no other combinational path from input to output.
- Reset asserted mid-operation: in-flight transactions are discarded; after release, no stale out_valid appears.
- Simultaneous accept and deliver with a full pipe is legal and sustains full rate.

## Configuration
- PIPELINED_ADDSUB_OVERFLOW_EN defined: overflow logic is built and the MSB sign bits of in1/in2 are pipelined alongside the transaction.
- Not defined: overflow is tied to 0, with no extra registers; the port remains present.

## Structure
- Shared package math_pkg: ceil_division and min functions; the addsub_op_e enum (ADD=0, SUB=1).
- Sub-module addsub_chunk: one slice, consisting of a combinational slice add/sub with carry-in/op producing the slice result and carry-out. The top module instantiates STAGES copies and owns all registers and the handshake.

## Test plan
- WIDTH=8, CHUNK=3 (STAGES=3), add 0xFF+0x01 → out=0x00, carry=1, overflow=0, out_valid 3 cycles after acceptance.
- Sub 0x00−0x01 → 0xFF, carry=1, overflow=0. Sub 0x80−0x01 → 0x7F, carry=0, overflow=1 (with the macro); overflow=0 without the macro.
- Back-to-back add 0x7F+0x01, sub 0x10−0x20, add 0x12+0x34 → 0x80/c0/ov1, 0xF0/c1/ov0, 0x46/c0/ov0 on consecutive cycles, in order.
- Fill the pipe, then hold out_ready=0 for 4 cycles → in_ready=0, out stable. On release, all 3 results drain one per cycle and none is lost.
- Assert rst_n low with 2 transactions in flight → outputs 0 immediately; after release, out_valid stays 0 until a new input is accepted.
- WIDTH=1, CHUNK=1: add 1+1 → out=0, carry=1, latency 1. Sub 0−1 → out=1, carry=1.
